// File: rtl/arbiter_final_pkg.sv
// Shared transmission-layer definitions for the VC-to-destination arbiter.
// Holds the default widths and the bundle carried between pipeline stages.
package arbiter_final_pkg;

    localparam int DATA_WIDTH  = 6;
    localparam int DEST_BIT    = 4;
    localparam int COUNT_WIDTH = 8;

    typedef enum logic {
        VC0 = 1'b0,
        VC1 = 1'b1
    } vc_sel_e;

    typedef struct packed {
        logic    valid;
        vc_sel_e vc;
    } stage1_t;

endpackage

// File: rtl/arbiter_final_counter.sv
// Wrapping per-destination push counter.
// Counts one per cycle that inc is high, modulo 2^count_width.
module packet_counter
    import arbiter_final_pkg::*;
#(
    parameter int count_width = COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   inc,
    output logic [count_width-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc) begin
            count <= count + count_width'(1);
        end
    end

endmodule

// File: rtl/arbiter_final.sv
// Two-VC to two-destination arbiter with strict VC0 priority.
// Pop -> capture -> push pipeline, two cycles from pop to push.
module arbiter_final
    import arbiter_final_pkg::*;
#(
    parameter int data_width  = DATA_WIDTH,
    parameter int dest_bit    = DEST_BIT,
    parameter int count_width = COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   empty_VC0,
    input  logic                   empty_VC1,
    input  logic [data_width-1:0]  data_in_VC0,
    input  logic [data_width-1:0]  data_in_VC1,
    input  logic                   almost_full_D0,
    input  logic                   almost_full_D1,
    output logic                   pop_VC0,
    output logic                   pop_VC1,
    output logic                   push_D0,
    output logic                   push_D1,
    output logic [data_width-1:0]  data_out_D0,
    output logic [data_width-1:0]  data_out_D1,
    output logic [count_width-1:0] count_D0,
    output logic [count_width-1:0] count_D1,
    output logic                   idle
);

    logic                  pause;
    logic                  to_d1;
    logic [data_width-1:0] word;
    stage1_t               s1_d;
    stage1_t               s1_q;

    assign pause   = almost_full_D0 | almost_full_D1;
    assign pop_VC0 = reset & ~empty_VC0 & ~pause;
    assign pop_VC1 = reset & empty_VC0 & ~empty_VC1 & ~pause;

    always_comb begin
        s1_d.valid = pop_VC0 | pop_VC1;
        s1_d.vc    = pop_VC1 ? VC1 : VC0;
    end

    // FIFO read data is valid the cycle after the pop
    assign word  = (s1_q.vc == VC1) ? data_in_VC1 : data_in_VC0;
    assign to_d1 = word[dest_bit];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q        <= '{valid: 1'b0, vc: VC0};
            push_D0     <= 1'b0;
            push_D1     <= 1'b0;
            data_out_D0 <= '0;
            data_out_D1 <= '0;
            idle        <= 1'b1;
        end else begin
            s1_q    <= s1_d;
            push_D0 <= s1_q.valid & ~to_d1;
            push_D1 <= s1_q.valid & to_d1;
            if (s1_q.valid && !to_d1) begin
                data_out_D0 <= word;
            end
            if (s1_q.valid && to_d1) begin
                data_out_D1 <= word;
            end
            // idle reflects the valids that will hold after this edge
            idle <= empty_VC0 & empty_VC1 & ~s1_d.valid & ~s1_q.valid;
        end
    end

    packet_counter #(
        .count_width(count_width)
    ) u_count_d0 (
        .clk  (clk),
        .reset(reset),
        .inc  (push_D0),
        .count(count_D0)
    );

    packet_counter #(
        .count_width(count_width)
    ) u_count_d1 (
        .clk  (clk),
        .reset(reset),
        .inc  (push_D1),
        .count(count_D1)
    );

endmodule

// File: tb/tb_arbiter_final.sv
// Scoreboard bench for arbiter_final: VC FIFO models feed the DUT,
// each pop queues its expected push, a negedge monitor checks pushes.
module tb_arbiter_final;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       empty_VC0 = 1'b1;
    logic       empty_VC1 = 1'b1;
    logic [5:0] data_in_VC0 = '0;
    logic [5:0] data_in_VC1 = '0;
    logic       almost_full_D0 = 1'b0;
    logic       almost_full_D1 = 1'b0;
    logic       pop_VC0, pop_VC1;
    logic       push_D0, push_D1;
    logic [5:0] data_out_D0, data_out_D1;
    logic [7:0] count_D0, count_D1;
    logic       idle;

    typedef struct {
        logic [5:0] word;
        logic       dest;
        int         cyc;
    } exp_t;

    logic [5:0] vc0_w[$];
    logic [5:0] vc1_w[$];
    logic       vc0_d[$];
    logic       vc1_d[$];
    exp_t       sb[$];

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    logic [7:0] exp_cnt0 = '0;
    logic [7:0] exp_cnt1 = '0;
    logic [5:0] last0 = '0;
    logic [5:0] last1 = '0;

    arbiter_final dut (
        .clk           (clk),
        .reset         (reset),
        .empty_VC0     (empty_VC0),
        .empty_VC1     (empty_VC1),
        .data_in_VC0   (data_in_VC0),
        .data_in_VC1   (data_in_VC1),
        .almost_full_D0(almost_full_D0),
        .almost_full_D1(almost_full_D1),
        .pop_VC0       (pop_VC0),
        .pop_VC1       (pop_VC1),
        .push_D0       (push_D0),
        .push_D1       (push_D1),
        .data_out_D0   (data_out_D0),
        .data_out_D1   (data_out_D1),
        .count_D0      (count_D0),
        .count_D1      (count_D1),
        .idle          (idle)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // VC FIFO models: record the expected push when a pop is seen
    always @(posedge clk) begin
        logic       p0, p1;
        logic [5:0] n0, n1;
        exp_t       e;
        p0 = pop_VC0;
        p1 = pop_VC1;
        n0 = data_in_VC0;
        n1 = data_in_VC1;
        chk("one_pop", {31'b0, p0 & p1}, 0);
        if (p0) begin
            if (vc0_w.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL pop_VC0_empty: got 1 expected 0");
            end else begin
                e.word = vc0_w.pop_front();
                e.dest = vc0_d.pop_front();
                e.cyc  = cyc;
                sb.push_back(e);
                n0 = e.word;
            end
        end
        if (p1) begin
            if (vc1_w.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL pop_VC1_empty: got 1 expected 0");
            end else begin
                e.word = vc1_w.pop_front();
                e.dest = vc1_d.pop_front();
                e.cyc  = cyc;
                sb.push_back(e);
                n1 = e.word;
            end
        end
        cyc++;
        #1;
        data_in_VC0 = n0;
        data_in_VC1 = n1;
        empty_VC0 = (vc0_w.size() == 0);
        empty_VC1 = (vc1_w.size() == 0);
    end

    always @(negedge clk) begin
        exp_t m;
        if (push_D0 || push_D1) begin
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_push: got D0=%0b D1=%0b expected none",
                         push_D0, push_D1);
            end else begin
                m = sb.pop_front();
                chk("push_D0", {31'b0, push_D0}, {31'b0, !m.dest});
                chk("push_D1", {31'b0, push_D1}, {31'b0, m.dest});
                chk("latency", cyc - m.cyc, 2);
                chk("count_D0", {24'b0, count_D0}, {24'b0, exp_cnt0});
                chk("count_D1", {24'b0, count_D1}, {24'b0, exp_cnt1});
                if (m.dest) begin
                    chk("data_out_D1", {26'b0, data_out_D1}, {26'b0, m.word});
                    chk("hold_D0", {26'b0, data_out_D0}, {26'b0, last0});
                    last1 = m.word;
                    exp_cnt1++;
                end else begin
                    chk("data_out_D0", {26'b0, data_out_D0}, {26'b0, m.word});
                    chk("hold_D1", {26'b0, data_out_D1}, {26'b0, last1});
                    last0 = m.word;
                    exp_cnt0++;
                end
            end
        end
        if (sb.size() != 0 && cyc - sb[0].cyc > 2) begin
            errors++;
            checks++;
            $display("FAIL missing_push: word %0h popped in %0d, none by %0d",
                     sb[0].word, sb[0].cyc, cyc);
            sb.delete(0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(logic vc, logic [5:0] w, logic dest);
        if (vc) begin
            vc1_w.push_back(w);
            vc1_d.push_back(dest);
            empty_VC1 = 1'b0;
        end else begin
            vc0_w.push_back(w);
            vc0_d.push_back(dest);
            empty_VC0 = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        sb.delete();
        exp_cnt0 = '0;
        exp_cnt1 = '0;
        last0 = '0;
        last1 = '0;
    endtask

    task automatic chk_reset_state(string tag);
        chk({tag, "_pop_VC0"}, {31'b0, pop_VC0}, 0);
        chk({tag, "_pop_VC1"}, {31'b0, pop_VC1}, 0);
        chk({tag, "_push_D0"}, {31'b0, push_D0}, 0);
        chk({tag, "_push_D1"}, {31'b0, push_D1}, 0);
        chk({tag, "_data_D0"}, {26'b0, data_out_D0}, 0);
        chk({tag, "_data_D1"}, {26'b0, data_out_D1}, 0);
        chk({tag, "_count_D0"}, {24'b0, count_D0}, 0);
        chk({tag, "_count_D1"}, {24'b0, count_D1}, 0);
        chk({tag, "_idle"}, {31'b0, idle}, 1);
    endtask

    task automatic drain(string name, int budget);
        int n = 0;
        while ((sb.size() != 0 || vc0_w.size() != 0 || vc1_w.size() != 0)
               && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: %0d words still pending after %0d cycles",
                     name, sb.size() + vc0_w.size() + vc1_w.size(), budget);
        end
    endtask

    initial begin
        // reset state with VC0 already holding a word
        load(1'b0, 6'h12, 1'b1);
        tick();
        tick();
        @(negedge clk);
        chk_reset_state("rst");

        // first pop in the first cycle after release
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("first_pop_VC0", {31'b0, pop_VC0}, 1);
        chk("first_pop_VC1", {31'b0, pop_VC1}, 0);
        drain("drain_single", 20);
        chk("single_count_D1", {24'b0, count_D1}, 1);
        chk("single_count_D0", {24'b0, count_D0}, 0);

        // VC0 priority; 0x21 has bit 4 clear, so it lands on D0
        tick();
        load(1'b0, 6'h05, 1'b0);
        load(1'b1, 6'h21, 1'b0);
        @(negedge clk);
        chk("prio_pop_VC0", {31'b0, pop_VC0}, 1);
        chk("prio_pop_VC1", {31'b0, pop_VC1}, 0);
        tick();
        @(negedge clk);
        chk("next_pop_VC0", {31'b0, pop_VC0}, 0);
        chk("next_pop_VC1", {31'b0, pop_VC1}, 1);
        drain("drain_prio", 20);

        tick();
        load(1'b1, 6'h31, 1'b1);
        @(negedge clk);
        chk("vc1_only_pop", {31'b0, pop_VC1}, 1);
        drain("drain_vc1", 20);

        // pause after two pops: in-flight words still pushed
        tick();
        load(1'b0, 6'h03, 1'b0);
        load(1'b0, 6'h14, 1'b1);
        load(1'b0, 6'h07, 1'b0);
        load(1'b1, 6'h15, 1'b1);
        tick();
        tick();
        almost_full_D0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("pause0_pop_VC0", {31'b0, pop_VC0}, 0);
            chk("pause0_pop_VC1", {31'b0, pop_VC1}, 0);
            tick();
        end
        almost_full_D0 = 1'b0;
        almost_full_D1 = 1'b1;
        @(negedge clk);
        chk("pause1_pop_VC0", {31'b0, pop_VC0}, 0);
        chk("pause1_idle", {31'b0, idle}, 0);
        tick();
        almost_full_D1 = 1'b0;
        @(negedge clk);
        chk("resume_pop_VC0", {31'b0, pop_VC0}, 1);
        drain("drain_pause", 20);

        // reset one cycle after a pop discards the word
        tick();
        load(1'b0, 6'h0A, 1'b0);
        @(negedge clk);
        chk("abort_pop", {31'b0, pop_VC0}, 1);
        tick();
        do_reset();
        @(negedge clk);
        chk_reset_state("mid");
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_push_D0", {31'b0, push_D0}, 0);
            chk("abort_push_D1", {31'b0, push_D1}, 0);
            chk("abort_idle", {31'b0, idle}, 1);
            tick();
        end

        // 256 pushes to D0 wrap its counter back to 0
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = i[7:0];
            load(1'b0, v[5:0] & 6'h2F, 1'b0);
        end
        drain("drain_wrap", 300);
        chk("wrap_count_D0", {24'b0, count_D0}, 0);
        chk("wrap_count_D1", {24'b0, count_D1}, 0);

        // idle timing around a lone pop in cycle N
        tick();
        tick();
        load(1'b0, 6'h13, 1'b1);
        @(negedge clk);
        chk("idle_pop_N", {31'b0, pop_VC0}, 1);
        tick();
        @(negedge clk);
        chk("idle_N1", {31'b0, idle}, 0);
        tick();
        @(negedge clk);
        chk("idle_N2", {31'b0, idle}, 0);
        chk("idle_N2_push", {31'b0, push_D1}, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("idle_high", {31'b0, idle}, 1);
            chk("idle_no_pop", {30'b0, pop_VC0, pop_VC1}, 0);
            chk("idle_no_push", {30'b0, push_D0, push_D1}, 0);
        end

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
